// File: rtl/reg_file.sv
// Register file with two registered read ports and one write port.
// Tracks a sticky ALU overflow flag and a saturating count of writes.
module reg_file #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [N-1:0]  rd_data_a,
  output logic [N-1:0]  rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [N-1:0]  wr_data,
  input  logic          ov_in,
  input  logic          ov_clr,
  output logic          ov_flag,
  output logic [7:0]    wr_cnt
);

  localparam int unsigned CW      = 8;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [N-1:0] regs [DEPTH];
  logic         wr_ok_c;
  logic         byp_a_c;
  logic         byp_b_c;
  logic [N-1:0] nxt_a_c;
  logic [N-1:0] nxt_b_c;

  // A write is accepted only when it targets a non-zero register.
  always_comb begin
    wr_ok_c = 1'b0;
    byp_a_c = 1'b0;
    byp_b_c = 1'b0;
    nxt_a_c = '0;
    nxt_b_c = '0;
    wr_ok_c = wr_en && (wr_addr != AW'(0));
    byp_a_c = wr_ok_c && (wr_addr == rd_addr_a);
    byp_b_c = wr_ok_c && (wr_addr == rd_addr_b);
    nxt_a_c = byp_a_c ? wr_data : regs[rd_addr_a];
    nxt_b_c = byp_b_c ? wr_data : regs[rd_addr_b];
  end

  // Storage; entry 0 is cleared at reset and never written, so it reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (wr_ok_c) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Registered read ports with write-first bypass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      rd_data_a <= nxt_a_c;
      rd_data_b <= nxt_b_c;
    end
  end

  // Sticky overflow: a qualified set beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_flag <= 1'b0;
    end else if (wr_en && ov_in) begin
      ov_flag <= 1'b1;
    end else if (ov_clr) begin
      ov_flag <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
    end else if (wr_ok_c && (wr_cnt != CNT_MAX)) begin
      wr_cnt <= wr_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file.
module tb_reg_file;

  localparam int unsigned N  = 32;
  localparam int unsigned AW = 3;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] rd_addr_a;
  logic [AW-1:0] rd_addr_b;
  logic [N-1:0]  rd_data_a;
  logic [N-1:0]  rd_data_b;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          ov_in;
  logic          ov_clr;
  logic          ov_flag;
  logic [7:0]    wr_cnt;

  int checks   = 0;
  int failures = 0;

  reg_file #(.N(N), .DEPTH(8), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_a (rd_data_a),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .ov_in     (ov_in),
    .ov_clr    (ov_clr),
    .ov_flag   (ov_flag),
    .wr_cnt    (wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we, input int wa, input int wd, input logic ov,
                       input logic clr, input int ra, input int rb);
    wr_en     = we;
    wr_addr   = AW'(wa);
    wr_data   = N'(wd);
    ov_in     = ov;
    ov_clr    = clr;
    rd_addr_a = AW'(ra);
    rd_addr_b = AW'(rb);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_rd_a", rd_data_a, 0);
    check("rst_rd_b", rd_data_b, 0);
    check("rst_ov", 32'(ov_flag), 0);
    check("rst_cnt", 32'(wr_cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Basic writes then reads
    drive(1, 1, 345, 0, 0, 0, 0); tick();
    drive(1, 2, 234, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 2);   tick();
    check("rd_r1", rd_data_a, 345);
    check("rd_r2", rd_data_b, 234);
    check("cnt_2", 32'(wr_cnt), 2);
    check("ov_idle", 32'(ov_flag), 0);

    // Bypass on both ports to same address
    drive(1, 3, 672, 0, 0, 3, 3); tick();
    check("byp_a", rd_data_a, 672);
    check("byp_b", rd_data_b, 672);
    check("cnt_3", 32'(wr_cnt), 3);

    // Bypass on one port only
    drive(1, 4, 11, 0, 0, 4, 1); tick();
    check("byp1_a", rd_data_a, 11);
    check("nobyp_b", rd_data_b, 345);

    // Writes to r0 are discarded
    drive(1, 0, 999, 0, 0, 0, 0); tick();
    check("r0_byp_a", rd_data_a, 0);
    check("r0_byp_b", rd_data_b, 0);
    check("cnt_r0", 32'(wr_cnt), 4);
    drive(0, 0, 0, 0, 0, 0, 3); tick();
    check("r0_rd", rd_data_a, 0);
    check("r3_rd", rd_data_b, 672);

    // Overflow flag behaviour
    drive(1, 6, 5, 1, 0, 6, 0); tick();
    check("ov_set", 32'(ov_flag), 1);
    check("cnt_5", 32'(wr_cnt), 5);
    drive(1, 0, 7, 1, 1, 6, 0); tick();
    check("ov_set_wins", 32'(ov_flag), 1);
    check("r6_rd", rd_data_a, 5);
    check("cnt_r0b", 32'(wr_cnt), 5);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check("ov_clr", 32'(ov_flag), 0);
    drive(0, 2, 1, 1, 0, 0, 0); tick();
    check("ov_no_we", 32'(ov_flag), 0);
    drive(1, 0, 1, 1, 0, 0, 0); tick();
    check("ov_r0_set", 32'(ov_flag), 1);
    drive(0, 0, 0, 0, 1, 0, 0); tick();
    check("ov_clr2", 32'(ov_flag), 0);

    // Saturating write counter: 5 writes so far, 300 more
    for (int i = 0; i < 300; i++) begin
      drive(1, 5, 1000 + i, 0, 0, 0, 0);
      tick();
      if (i == 248) check("cnt_254", 32'(wr_cnt), 254);
      if (i == 249) check("cnt_255", 32'(wr_cnt), 255);
    end
    drive(0, 0, 0, 0, 0, 5, 5); tick();
    check("cnt_sat", 32'(wr_cnt), 255);
    check("r5_last", rd_data_a, 1299);

    // Asynchronous reset between edges
    drive(1, 1, 213, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 1);   tick();
    check("r1_213_a", rd_data_a, 213);
    check("r1_213_b", rd_data_b, 213);
    check("ov_pre_rst", 32'(ov_flag), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_rd_a", rd_data_a, 0);
    check("arst_rd_b", rd_data_b, 0);
    check("arst_ov", 32'(ov_flag), 0);
    check("arst_cnt", 32'(wr_cnt), 0);
    // Write attempted while reset is held is lost
    drive(1, 2, 77, 1, 0, 2, 2);
    tick();
    check("rst_hold_a", rd_data_a, 0);
    check("rst_hold_ov", 32'(ov_flag), 0);
    #2;
    rst_n = 1'b1;

    // First edge after release operates normally
    drive(1, 7, 42, 0, 0, 1, 2); tick();
    check("post_r1", rd_data_a, 0);
    check("post_r2", rd_data_b, 0);
    check("post_cnt", 32'(wr_cnt), 1);
    drive(0, 0, 0, 0, 0, 7, 7); tick();
    check("post_r7_a", rd_data_a, 42);
    check("post_r7_b", rd_data_b, 42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
